dot_product_acc: RTL and testbench

DOT_PRODUCT_ACC -- requirements
Module: dot_product_acc

---
 rtl/dot_product_acc.sv | 140 ++++++++++++++
 tb/tb_dot_product_acc.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dot_product_acc.sv
// Streaming fixed-point dot product with bias, round-half-up and optional clipping.
// Define DOTP_ACC_SAT_EN to clip the result and report it on out_sat.
module dot_product_acc #(
    parameter int DATA_WIDTH = 14,
    parameter int FRAC_BITS  = 10,
    parameter int VEC_LEN    = 16,
    parameter int PROD_WIDTH = 28
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic signed [DATA_WIDTH-1:0] bias,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_sat
);

    localparam int CW    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int ACC_W = PROD_WIDTH + $clog2(VEC_LEN) + 1;
    localparam int XW    = PROD_WIDTH - DATA_WIDTH;

    localparam logic signed [ACC_W:0] HALF =
        {{(ACC_W - FRAC_BITS + 1){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        ROUND = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic        [CW-1:0]         cnt;
    logic signed [ACC_W-1:0]      acc;
    logic signed [PROD_WIDTH-1:0] a_x, b_x, prod;
    logic signed [ACC_W-1:0]      prod_ext, bias_ext;
    logic signed [ACC_W:0]        rnd, r;
    logic                         beat, last;

    assign a_x  = {{XW{a[DATA_WIDTH-1]}}, a};
    assign b_x  = {{XW{b[DATA_WIDTH-1]}}, b};
    assign prod = a_x * b_x;

    assign prod_ext = {{(ACC_W - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
    assign bias_ext = {{(ACC_W - DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias}
                      <<< FRAC_BITS;

    assign beat = in_valid && in_ready;
    assign last = (cnt == CW'(VEC_LEN - 1));

    // One extra bit so adding the rounding half can never wrap.
    assign rnd = {acc[ACC_W-1], acc} + HALF;
    assign r   = rnd >>> FRAC_BITS;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ACCUM:   if (beat && last) state_nxt = ROUND;
            ROUND:   state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ACCUM:   in_ready  = 1'b1;
            OUT:     out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (beat) begin
            cnt <= last ? '0 : cnt + 1'b1;
            acc <= (cnt == '0) ? bias_ext + prod_ext : acc + prod_ext;
        end
    end

`ifdef DOTP_ACC_SAT_EN
    localparam logic signed [ACC_W:0] MAXV =
        {{(ACC_W - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV =
        {{(ACC_W - DATA_WIDTH + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    logic sat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            sat_q    <= 1'b0;
        end else if (state == ROUND) begin
            if (r > MAXV) begin
                out_data <= {1'b0, {(DATA_WIDTH - 1){1'b1}}};
                sat_q    <= 1'b1;
            end else if (r < MINV) begin
                out_data <= {1'b1, {(DATA_WIDTH - 1){1'b0}}};
                sat_q    <= 1'b1;
            end else begin
                out_data <= r[DATA_WIDTH-1:0];
                sat_q    <= 1'b0;
            end
        end
    end

    assign out_sat = sat_q;
`else
    logic unused_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
        end else if (state == ROUND) begin
            out_data <= r[DATA_WIDTH-1:0];
        end
    end

    // Wrapping result: bits above the output width are dropped.
    assign unused_hi = ^r[ACC_W:DATA_WIDTH];
    assign out_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_dot_product_acc.sv
// Directed bench for dot_product_acc at VEC_LEN 4, 1 and 16.
// Table vectors plus hand sequences for backpressure and reset.
module tb_dot_product_acc;

    localparam int DW = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic iv [3];
    logic orr [3];
    logic ir [3];
    logic ov [3];
    logic osat [3];
    logic signed [DW-1:0] a [3];
    logic signed [DW-1:0] b [3];
    logic signed [DW-1:0] bias [3];
    logic signed [DW-1:0] od [3];

    dot_product_acc #(
        .DATA_WIDTH(14), .FRAC_BITS(10), .VEC_LEN(4), .PROD_WIDTH(28)
    ) u_v4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a[0]), .b(b[0]), .bias(bias[0]), .out_valid(ov[0]),
        .out_ready(orr[0]), .out_data(od[0]), .out_sat(osat[0])
    );

    dot_product_acc #(
        .DATA_WIDTH(14), .FRAC_BITS(10), .VEC_LEN(1), .PROD_WIDTH(28)
    ) u_v1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a[1]), .b(b[1]), .bias(bias[1]), .out_valid(ov[1]),
        .out_ready(orr[1]), .out_data(od[1]), .out_sat(osat[1])
    );

    dot_product_acc #(
        .DATA_WIDTH(14), .FRAC_BITS(10), .VEC_LEN(16), .PROD_WIDTH(28)
    ) u_v16 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a[2]), .b(b[2]), .bias(bias[2]), .out_valid(ov[2]),
        .out_ready(orr[2]), .out_data(od[2]), .out_sat(osat[2])
    );

    typedef struct {
        int d;
        int n;
        int gap;
        int av;
        int bv;
        int biasv;
        int exp_data;
        int exp_sat;
    } vec_t;

    vec_t tbl [10];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive n beats (optionally with idle gaps), then check the 2-cycle latency.
    task automatic beats(input int d, input int n, input int gap,
                         input int av, input int bv, input int biasv,
                         input string name);
        for (int i = 0; i < n; i++) begin
            iv[d]   = 1'b1;
            a[d]    = DW'(av);
            b[d]    = DW'(bv);
            bias[d] = (i == 0) ? DW'(biasv) : DW'(1234);
            chk({name, " in_ready"}, int'(ir[d]), 1);
            @(negedge clk);
            if (gap != 0 && i < n - 1) begin
                iv[d] = 1'b0;
                a[d]  = DW'(-777);
                @(negedge clk);
                chk({name, " gap in_ready"}, int'(ir[d]), 1);
            end
        end
        iv[d] = 1'b0;
        chk({name, " round out_valid"}, int'(ov[d]), 0);
        @(negedge clk);
        chk({name, " out_valid"}, int'(ov[d]), 1);
    endtask

    task automatic accept(input int d, input string name);
        orr[d] = 1'b1;
        @(negedge clk);
        orr[d] = 1'b0;
        chk({name, " out_valid after accept"}, int'(ov[d]), 0);
        chk({name, " in_ready after accept"}, int'(ir[d]), 1);
    endtask

    initial begin
        tbl[0] = '{0, 4, 1, 1024, 1024, 0, 4096, 0};
        tbl[1] = '{0, 4, 0, -1024, 512, 256, -1792, 0};
        tbl[2] = '{1, 1, 0, 1, 512, 0, 1, 0};
        tbl[3] = '{1, 1, 0, -1, 512, 0, 0, 0};
        tbl[4] = '{1, 1, 0, 2048, -1536, -3, -3075, 0};
        tbl[5] = '{1, 1, 0, -3, 512, 0, -1, 0};
`ifdef DOTP_ACC_SAT_EN
        tbl[6] = '{2, 16, 0, 8191, 8191, 0, 8191, 1};
        tbl[7] = '{0, 4, 0, -8192, -8192, 0, 8191, 1};
        tbl[8] = '{1, 1, 0, -8192, 8191, 0, -8192, 1};
`else
        tbl[6] = '{2, 16, 0, 8191, 8191, 0, -256, 0};
        tbl[7] = '{0, 4, 0, -8192, -8192, 0, 0, 0};
        tbl[8] = '{1, 1, 0, -8192, 8191, 0, 8, 0};
`endif
        tbl[9] = '{2, 16, 1, 512, 1024, -20, 8172, 0};

        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            iv[d]   = 1'b0;
            orr[d]  = 1'b0;
            a[d]    = '0;
            b[d]    = '0;
            bias[d] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset in_ready %0d", d), int'(ir[d]), 1);
            chk($sformatf("reset out_valid %0d", d), int'(ov[d]), 0);
            chk($sformatf("reset out_data %0d", d), int'(od[d]), 0);
            chk($sformatf("reset out_sat %0d", d), int'(osat[d]), 0);
        end

        for (int t = 0; t < 10; t++) begin
            string nm;
            nm = $sformatf("vec%0d", t);
            beats(tbl[t].d, tbl[t].n, tbl[t].gap, tbl[t].av, tbl[t].bv,
                  tbl[t].biasv, nm);
            chk({nm, " out_data"}, int'(od[tbl[t].d]), tbl[t].exp_data);
            chk({nm, " out_sat"}, int'(osat[tbl[t].d]), tbl[t].exp_sat);
            accept(tbl[t].d, nm);
        end

        // Backpressure: result held, offered beats ignored while in OUT.
        beats(0, 4, 0, 1024, 1024, 0, "hold");
        for (int i = 0; i < 5; i++) begin
            iv[0] = 1'b1;
            a[0]  = DW'(-1024);
            b[0]  = DW'(-1024);
            @(negedge clk);
            chk("hold out_valid", int'(ov[0]), 1);
            chk("hold in_ready", int'(ir[0]), 0);
            chk("hold out_data", int'(od[0]), 4096);
        end
        iv[0] = 1'b0;
        accept(0, "hold");
        beats(0, 4, 0, 512, 1024, 0, "after hold");
        chk("after hold out_data", int'(od[0]), 2048);
        accept(0, "after hold");

        // Reset mid-vector drops the partial sum.
        for (int i = 0; i < 2; i++) begin
            iv[0]   = 1'b1;
            a[0]    = DW'(1024);
            b[0]    = DW'(1024);
            bias[0] = '0;
            @(negedge clk);
        end
        iv[0] = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst in_ready", int'(ir[0]), 1);
        chk("midrst out_data", int'(od[0]), 0);
        beats(0, 4, 0, 1024, 1024, 0, "midrst");
        chk("midrst result", int'(od[0]), 4096);
        accept(0, "midrst");

        // Reset while a result is pending in OUT.
        beats(1, 1, 0, 1024, 1024, 0, "outrst");
        chk("outrst pending", int'(od[1]), 1024);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("outrst out_valid", int'(ov[1]), 0);
        chk("outrst out_data", int'(od[1]), 0);
        chk("outrst in_ready", int'(ir[1]), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
